// File: rtl/dm_cache_controller_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Holds the cache command codes, the controller state encoding and the
// default data/address/statistics widths.
package dm_cache_controller_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_STAT_WIDTH = 16;

    // Commands understood by the cache array. READ doubles as the idle
    // command because it has no side effects on the array.
    typedef enum logic [1:0] {
        CMD_CLR   = 2'b00,
        CMD_CHECK = 2'b01,
        CMD_READ  = 2'b10,
        CMD_WRITE = 2'b11
    } cacheCmd_e;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WB      = 3'd3,
        ST_FILL    = 3'd4,
        ST_INSTALL = 3'd5,
        ST_RDCACHE = 3'd6,
        ST_WRCACHE = 3'd7
    } ctrlState_e;

    // States that hold a request open towards main RAM.
    function automatic logic usesRam(input ctrlState_e s);
        return (s == ST_WB) || (s == ST_FILL);
    endfunction

endpackage

// File: rtl/dm_cache_controller_sat_counter.sv
// Saturating event counter used for the hit/miss statistics.
// Only compiled when CACHE_STATS_EN is defined; without it the statistics
// hardware does not exist at all.
`ifdef CACHE_STATS_EN
module sat_counter #(
    parameter int width = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/dm_cache_controller.sv
// Sequencing controller between the processor memory port and a
// direct-mapped cache array, with dirty-victim writeback and miss fill to
// main RAM over a req/ack handshake. Every output is registered.
// Optional hit/miss statistics are enabled with the CACHE_STATS_EN macro.
module dm_cache_controller
    import dm_cache_controller_pkg::*;
#(
    parameter int dataWidth = DEF_DATA_WIDTH,
    parameter int addrWidth = DEF_ADDR_WIDTH
`ifdef CACHE_STATS_EN
    ,
    parameter int statWidth = DEF_STAT_WIDTH
`endif
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [addrWidth-1:0] addr,
    input  logic [dataWidth-1:0] wdata,
    output logic                 ready,
    output logic                 done,
    output logic [dataWidth-1:0] rdata,
    output logic [1:0]           cntrl,
    output logic [addrWidth-1:0] cacheAddr,
    output logic [dataWidth-1:0] cacheDataIn,
    input  logic [dataWidth-1:0] cacheDataOut,
    input  logic                 isHit,
    input  logic                 isClean,
    input  logic [dataWidth-1:0] victimData,
    input  logic [addrWidth-1:0] victimAddr,
    output logic                 ramReq,
    output logic                 ramWe,
    output logic [addrWidth-1:0] ramAddr,
    output logic [dataWidth-1:0] ramWData,
    input  logic [dataWidth-1:0] ramRData,
    input  logic                 ramAck
`ifdef CACHE_STATS_EN
    ,
    output logic [statWidth-1:0] hitCount,
    output logic [statWidth-1:0] missCount
`endif
);

    ctrlState_e           state_q, state_d;

    logic [addrWidth-1:0] reqAddr_q;
    logic                 reqWe_q;
    logic [dataWidth-1:0] reqWData_q;

    cacheCmd_e            cntrl_q, cntrl_d;
    logic [addrWidth-1:0] cacheAddr_q, cacheAddr_d;
    logic [dataWidth-1:0] cacheDataIn_q, cacheDataIn_d;
    logic                 ramReq_q, ramReq_d;
    logic                 ramWe_q, ramWe_d;
    logic [addrWidth-1:0] ramAddr_q, ramAddr_d;
    logic [dataWidth-1:0] ramWData_q, ramWData_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;

    logic                 acceptReq;

    // A request raised in the same cycle as the completion pulse belongs to
    // the transaction that just finished, so it is not accepted.
    assign acceptReq = req && !done_q;

    // State register; reset parks the controller in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing of a single processor access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:   state_d = ST_IDLE;
            ST_IDLE:    if (acceptReq) state_d = ST_CHECK;
            ST_CHECK: begin
                if (isHit) begin
                    state_d = reqWe_q ? ST_WRCACHE : ST_RDCACHE;
                end else if (!isClean) begin
                    state_d = ST_WB;
                end else begin
                    state_d = reqWe_q ? ST_WRCACHE : ST_FILL;
                end
            end
            ST_WB:      if (ramAck) state_d = reqWe_q ? ST_WRCACHE : ST_FILL;
            ST_FILL:    if (ramAck) state_d = ST_INSTALL;
            ST_INSTALL: state_d = ST_RDCACHE;
            ST_RDCACHE: state_d = ST_IDLE;
            ST_WRCACHE: state_d = ST_IDLE;
            default:    state_d = ST_CLEAR;
        endcase
    end

    // Output values for the state being entered, so the registered outputs
    // line up with the registered state.
    always_comb begin
        cntrl_d       = CMD_READ;
        cacheAddr_d   = cacheAddr_q;
        cacheDataIn_d = cacheDataIn_q;
        ramAddr_d     = ramAddr_q;
        ramWData_d    = ramWData_q;
        ramReq_d      = usesRam(state_d);
        ramWe_d       = (state_d == ST_WB);
        ready_d       = (state_d == ST_IDLE);
        done_d        = (state_q == ST_RDCACHE) || (state_q == ST_WRCACHE);
        rdata_d       = (state_q == ST_RDCACHE) ? cacheDataOut : rdata_q;

        case (state_d)
            ST_CLEAR:   cntrl_d = CMD_CLR;
            ST_CHECK: begin
                cntrl_d     = CMD_CHECK;
                cacheAddr_d = addr;
            end
            ST_WB: begin
                cacheAddr_d = reqAddr_q;
                if (state_q == ST_CHECK) begin
                    ramAddr_d  = victimAddr;
                    ramWData_d = victimData;
                end
            end
            ST_FILL: begin
                cacheAddr_d = reqAddr_q;
                ramAddr_d   = reqAddr_q;
            end
            ST_INSTALL: begin
                cntrl_d       = CMD_WRITE;
                cacheAddr_d   = reqAddr_q;
                cacheDataIn_d = ramRData;
            end
            ST_RDCACHE: cacheAddr_d = reqAddr_q;
            ST_WRCACHE: begin
                cntrl_d       = CMD_WRITE;
                cacheAddr_d   = reqAddr_q;
                cacheDataIn_d = reqWData_q;
            end
            default:    cntrl_d = CMD_READ;
        endcase
    end

    // Output registers; reset drops the RAM request at once, abandoning any
    // transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntrl_q       <= CMD_CLR;
            cacheAddr_q   <= '0;
            cacheDataIn_q <= '0;
            ramReq_q      <= 1'b0;
            ramWe_q       <= 1'b0;
            ramAddr_q     <= '0;
            ramWData_q    <= '0;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
        end else begin
            cntrl_q       <= cntrl_d;
            cacheAddr_q   <= cacheAddr_d;
            cacheDataIn_q <= cacheDataIn_d;
            ramReq_q      <= ramReq_d;
            ramWe_q       <= ramWe_d;
            ramAddr_q     <= ramAddr_d;
            ramWData_q    <= ramWData_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
        end
    end

    // Capture the processor request when it is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqAddr_q  <= '0;
            reqWe_q    <= 1'b0;
            reqWData_q <= '0;
        end else if ((state_q == ST_IDLE) && acceptReq) begin
            reqAddr_q  <= addr;
            reqWe_q    <= we;
            reqWData_q <= wdata;
        end
    end

    assign cntrl       = cntrl_q;
    assign cacheAddr   = cacheAddr_q;
    assign cacheDataIn = cacheDataIn_q;
    assign ramReq      = ramReq_q;
    assign ramWe       = ramWe_q;
    assign ramAddr     = ramAddr_q;
    assign ramWData    = ramWData_q;
    assign ready       = ready_q;
    assign done        = done_q;
    assign rdata       = rdata_q;

`ifdef CACHE_STATS_EN
    logic hitInc;
    logic missInc;

    // Each request resolves exactly once, in its single CHECK cycle.
    assign hitInc  = (state_q == ST_CHECK) && isHit;
    assign missInc = (state_q == ST_CHECK) && !isHit;

    sat_counter #(.width(statWidth)) uHitCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hitInc),
        .count (hitCount)
    );

    sat_counter #(.width(statWidth)) uMissCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (missInc),
        .count (missCount)
    );
`endif

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller. Surrounds the controller with
// a 16-line direct-mapped cache array model (negedge) and a RAM model with
// programmable acknowledge latency, then runs directed scenarios followed by
// random accesses compared against a memory-level reference model.
module tb_dm_cache_controller;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
    } ramOp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req   = 1'b0;
    logic       we    = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
    logic [1:0] cntrl;
    logic [7:0] cacheAddr;
    logic [7:0] cacheDataIn;
    logic [7:0] cacheDataOut = 8'h00;
    logic       isHit        = 1'b0;
    logic       isClean      = 1'b1;
    logic [7:0] victimData   = 8'h00;
    logic [7:0] victimAddr   = 8'h00;
    logic       ramReq;
    logic       ramWe;
    logic [7:0] ramAddr;
    logic [7:0] ramWData;
    logic [7:0] ramRData = 8'h00;
    logic       ramAck   = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] aTag[16];
    logic [7:0] aData[16];
    logic       aDirty[16];

    logic [7:0] ram[256];
    int         fixedLat = 2;
    ramOp_t     ramLog[$];

    logic [7:0] golden[256];
    logic [3:0] refTag[16];
    logic       refDirty[16];
    int         refHits = 0;
    int         refMisses = 0;

    dm_cache_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .cntrl        (cntrl),
        .cacheAddr    (cacheAddr),
        .cacheDataIn  (cacheDataIn),
        .cacheDataOut (cacheDataOut),
        .isHit        (isHit),
        .isClean      (isClean),
        .victimData   (victimData),
        .victimAddr   (victimAddr),
        .ramReq       (ramReq),
        .ramWe        (ramWe),
        .ramAddr      (ramAddr),
        .ramWData     (ramWData),
        .ramRData     (ramRData),
        .ramAck       (ramAck)
`ifdef CACHE_STATS_EN
        ,
        .hitCount     (hitCount),
        .missCount    (missCount)
`endif
    );

    always #5 clk = ~clk;

    // Cache array: 16 lines, index addr[3:0], tag addr[7:4]; acts on negedge.
    always @(negedge clk) begin
        case (cntrl)
            2'b00: begin
                for (int i = 0; i < 16; i++) begin
                    aTag[i]   <= 4'h0;
                    aData[i]  <= 8'h00;
                    aDirty[i] <= 1'b0;
                end
            end
            2'b01: begin
                isHit      <= (aTag[cacheAddr[3:0]] == cacheAddr[7:4]);
                isClean    <= !aDirty[cacheAddr[3:0]];
                victimData <= aData[cacheAddr[3:0]];
                victimAddr <= {aTag[cacheAddr[3:0]], cacheAddr[3:0]};
            end
            2'b10: cacheDataOut <= aData[cacheAddr[3:0]];
            default: begin
                aTag[cacheAddr[3:0]]   <= cacheAddr[7:4];
                aData[cacheAddr[3:0]]  <= cacheDataIn;
                aDirty[cacheAddr[3:0]] <= 1'b1;
            end
        endcase
    end

    // RAM: acknowledges each request curLat cycles after it rises.
    initial begin
        int cnt;
        int curLat;
        ramOp_t op;
        cnt = 0;
        curLat = 1;
        forever begin
            @(posedge clk);
            #1;
            if (ramAck) ramAck = 1'b0;
            if (ramReq) begin
                if (cnt == 0) curLat = (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 3));
                cnt++;
                if (cnt == curLat) begin
                    op.we  = ramWe;
                    op.a   = ramAddr;
                    op.lat = curLat;
                    if (ramWe) begin
                        ram[ramAddr] = ramWData;
                        op.d = ramWData;
                    end else begin
                        ramRData = ram[ramAddr];
                        op.d = ram[ramAddr];
                    end
                    ramLog.push_back(op);
                    ramAck = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstCntrl", 32'(cntrl), 0);
        checkOutput("rstRamReq", 32'(ramReq), 0);
        checkOutput("rstReady", 32'(ready), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstRdata", 32'(rdata), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("relReady", 32'(ready), 1);
        checkOutput("relCntrl", 32'(cntrl), 2);
    endtask

    // One processor access; lat counts the cycle after the sampling edge as 1.
    task automatic applyStimulus(input logic isWrite, input logic [7:0] a, input logic [7:0] d,
                                 output int lat, output logic [7:0] rd);
        int guard;
        logic gotDone;
        guard = 0;
        @(negedge clk);
        while (!(ready && !done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ramLog.delete();
        req = 1'b1;
        we = isWrite;
        addr = a;
        wdata = d;
        @(posedge clk);
        lat = 1;
        gotDone = 1'b0;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) gotDone = 1'b1;
        end
        rd = rdata;
        req = 1'b0;
        checkOutput("doneSeen", 32'(gotDone), 1);
    endtask

    task automatic refReset();
        for (int i = 0; i < 256; i++) golden[i] = ram[i];
        for (int i = 0; i < 16; i++) begin
            refTag[i] = 4'h0;
            refDirty[i] = 1'b0;
        end
        refHits = 0;
        refMisses = 0;
    endtask

    // Random access predicted from direct-mapped write-back semantics.
    task automatic randomAccess();
        logic isWrite;
        logic [7:0] a, d, rd, victim;
        logic [3:0] idx, tag;
        logic hit, wb, fill;
        int lat, ramSum, expLat, k;
        isWrite = 1'($urandom_range(0, 1));
        a = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
        d = 8'($urandom);
        idx = a[3:0];
        tag = a[7:4];
        hit = (refTag[idx] == tag);
        wb = !hit && refDirty[idx];
        fill = !hit && !isWrite;
        victim = {refTag[idx], idx};
        applyStimulus(isWrite, a, d, lat, rd);
        ramSum = 0;
        foreach (ramLog[i]) ramSum += ramLog[i].lat;
        expLat = hit ? 3 : ((isWrite ? 3 : 4) + ramSum);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("ramOps", 32'(ramLog.size()), 32'(int'(wb) + int'(fill)));
        k = 0;
        if (wb) begin
            if (ramLog.size() > k) begin
                checkOutput("wbWe", 32'(ramLog[k].we), 1);
                checkOutput("wbAddr", 32'(ramLog[k].a), 32'(victim));
                checkOutput("wbData", 32'(ramLog[k].d), 32'(golden[victim]));
            end
            k++;
        end
        if (fill && ramLog.size() > k) begin
            checkOutput("fillWe", 32'(ramLog[k].we), 0);
            checkOutput("fillAddr", 32'(ramLog[k].a), 32'(a));
        end
        if (!isWrite) checkOutput("rdata", 32'(rd), 32'(golden[a]));
        if (hit) refHits++; else refMisses++;
        if (isWrite) golden[a] = d;
        if (!hit || isWrite) begin
            refTag[idx] = tag;
            refDirty[idx] = 1'b1;
        end
    endtask

    initial begin
        int lat;
        logic [7:0] rd;
        logic [7:0] exp22;
        logic doneSeen;
        int guard;

        for (int i = 0; i < 256; i++) ram[i] = (i < 16) ? 8'h00 : 8'($urandom);
        ram[8'h35] = 8'hA7;
        exp22 = ram[8'h22];

        $display("[TB] reset");
        resetDut();

        $display("[TB] cold read miss of 0x35");
        fixedLat = 2;
        applyStimulus(1'b0, 8'h35, 8'h00, lat, rd);
        checkOutput("coldLat", 32'(lat), 6);
        checkOutput("coldRdata", 32'(rd), 32'hA7);
        checkOutput("coldOps", 32'(ramLog.size()), 1);
        if (ramLog.size() > 0) begin
            checkOutput("coldFillWe", 32'(ramLog[0].we), 0);
            checkOutput("coldFillAddr", 32'(ramLog[0].a), 32'h35);
        end

        $display("[TB] read hit of 0x35");
        applyStimulus(1'b0, 8'h35, 8'h00, lat, rd);
        checkOutput("hitLat", 32'(lat), 3);
        checkOutput("hitRdata", 32'(rd), 32'hA7);
        checkOutput("hitOps", 32'(ramLog.size()), 0);

        $display("[TB] dirty eviction");
        applyStimulus(1'b1, 8'h12, 8'h5C, lat, rd);
        checkOutput("wrMissLat", 32'(lat), 3);
        checkOutput("wrMissOps", 32'(ramLog.size()), 0);
        applyStimulus(1'b0, 8'h22, 8'h00, lat, rd);
        checkOutput("evictLat", 32'(lat), 8);
        checkOutput("evictOps", 32'(ramLog.size()), 2);
        if (ramLog.size() > 1) begin
            checkOutput("evictWbWe", 32'(ramLog[0].we), 1);
            checkOutput("evictWbAddr", 32'(ramLog[0].a), 32'h12);
            checkOutput("evictWbData", 32'(ramLog[0].d), 32'h5C);
            checkOutput("evictFillWe", 32'(ramLog[1].we), 0);
            checkOutput("evictFillAddr", 32'(ramLog[1].a), 32'h22);
        end
        checkOutput("evictRdata", 32'(rd), 32'(exp22));
        checkOutput("ramAt12", 32'(ram[8'h12]), 32'h5C);

        $display("[TB] write hit then read hit of 0x22");
        applyStimulus(1'b1, 8'h22, 8'h11, lat, rd);
        checkOutput("wrHitLat", 32'(lat), 3);
        checkOutput("wrHitOps", 32'(ramLog.size()), 0);
        applyStimulus(1'b0, 8'h22, 8'h00, lat, rd);
        checkOutput("rdBackLat", 32'(lat), 3);
        checkOutput("rdBackRdata", 32'(rd), 32'h11);
        checkOutput("rdBackOps", 32'(ramLog.size()), 0);

        $display("[TB] reset during fill");
        fixedLat = 3;
        guard = 0;
        @(negedge clk);
        while (!(ready && !done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ramLog.delete();
        req = 1'b1;
        we = 1'b0;
        addr = 8'h47;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("abortFillReq", 32'(ramReq), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortReqDrop", 32'(ramReq), 0);
        req = 1'b0;
        doneSeen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) doneSeen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done) doneSeen = 1'b1;
        checkOutput("abortNoDone", 32'(doneSeen), 0);
        checkOutput("abortNoRamOp", 32'(ramLog.size()), 0);
        checkOutput("abortReady", 32'(ready), 1);
        fixedLat = 2;
        applyStimulus(1'b0, 8'h35, 8'h00, lat, rd);
        checkOutput("reMissLat", 32'(lat), 6);
        checkOutput("reMissRdata", 32'(rd), 32'hA7);
        checkOutput("reMissOps", 32'(ramLog.size()), 1);
        if (ramLog.size() > 0) checkOutput("reMissAddr", 32'(ramLog[0].a), 32'h35);

        $display("[TB] random accesses against reference model");
        resetDut();
        refReset();
        fixedLat = 0;
        repeat (200) randomAccess();
`ifdef CACHE_STATS_EN
        checkOutput("hitCount", 32'(hitCount), 32'(refHits));
        checkOutput("missCount", 32'(missCount), 32'(refMisses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
